// File: rtl/ysyx_220066_scoreboard.sv
// rtl/ysyx_220066_scoreboard.sv - register scoreboard and issue controller for the ID/EX boundary
module ysyx_220066_scoreboard #(
    parameter int NREG   = 32,
    parameter int CNT_W  = 2,
    parameter int BYPASS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic       rs1_used,
    input  logic       rs2_used,
    output logic       rs1_valid,
    output logic       rs2_valid,
    input  logic       issue_valid,
    input  logic [4:0] issue_rd,
    input  logic       issue_regwr,
    input  logic       issue_md,
    output logic       issue_ready,
    input  logic       wb0_valid,
    input  logic [4:0] wb0_rd,
    input  logic       wb1_valid,
    input  logic [4:0] wb1_rd,
    output logic       pending_any,
    output logic       err
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt     [NREG];
    logic [1:0]       dec     [NREG];
    logic [CNT_W:0]   cnt_nxt [NREG];
    logic             md_busy;
    logic             fire;
    logic             under_flow;
    logic             any_cnt;

    assign fire = issue_valid & issue_ready;

    // Per-register retire count and next value; a negative result is a protocol error.
    always_comb begin
        under_flow = 1'b0;
        any_cnt    = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            dec[r]     = 2'd0;
            cnt_nxt[r] = '0;
            if (r != 0) begin
                dec[r] = {1'b0, wb0_valid && (wb0_rd == 5'(r))}
                       + {1'b0, wb1_valid && (wb1_rd == 5'(r))};
                cnt_nxt[r] = {1'b0, cnt[r]}
                           + (CNT_W+1)'(fire && issue_regwr && (issue_rd == 5'(r)))
                           - (CNT_W+1)'(dec[r]);
                if (cnt_nxt[r][CNT_W])
                    under_flow = 1'b1;
                if (cnt[r] != '0)
                    any_cnt = 1'b1;
            end
        end
    end

    function automatic logic src_ok(input logic [4:0] a, input logic [CNT_W-1:0] c,
                                    input logic [1:0] d);
        logic [CNT_W:0] diff;
        diff = {1'b0, c} - (CNT_W+1)'(d);
        return (a == 5'd0) || (c == '0) || ((BYPASS != 0) && (diff == '0));
    endfunction

    assign rs1_valid = src_ok(rs1_addr, cnt[rs1_addr], dec[rs1_addr]);
    assign rs2_valid = src_ok(rs2_addr, cnt[rs2_addr], dec[rs2_addr]);

    // A full counter refuses the issue even when that register retires this cycle.
    assign issue_ready = ~(rs1_used & ~rs1_valid)
                       & ~(rs2_used & ~rs2_valid)
                       & ~(issue_regwr && (issue_rd != 5'd0) && (cnt[issue_rd] == MAX))
                       & ~(issue_md & md_busy & ~wb1_valid);

    assign pending_any = md_busy | any_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
            md_busy <= 1'b0;
            err     <= 1'b0;
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NREG; r++)
                cnt[r] <= cnt_nxt[r][CNT_W] ? '0 : cnt_nxt[r][CNT_W-1:0];
            if (fire && issue_md)
                md_busy <= 1'b1;
            else if (wb1_valid)
                md_busy <= 1'b0;
            if (under_flow || (wb1_valid && !md_busy))
                err <= 1'b1;
        end
    end

endmodule

// File: doc/ysyx_220066_scoreboard.md
# ysyx_220066_scoreboard

Register scoreboard and issue controller between the ID stage and the execute/writeback paths of the RV64 core. It tracks outstanding writes per integer register, serialises the single multi-cycle multiply/divide unit, and produces `rs1_valid`/`rs2_valid` for ID and `issue_ready` for the issue handshake. ID stalls (`rs_block`) on its outputs; EX/MD writeback and squashed-instruction retirement release entries.

## Interface
- `NREG`, 32: number of tracked registers; x0 is never tracked.
- `CNT_W`, 2: pending-counter width; `MAX = 2^CNT_W - 1`.
- `BYPASS`, 1: if 1, a register whose last pending write retires this cycle reads as valid this cycle.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rs1_addr`, `rs2_addr` in 5: source registers of the instruction in ID.
- `rs1_used`, `rs2_used` in 1: instruction actually reads that source.
- `rs1_valid`, `rs2_valid` out 1: source has no outstanding writer.
- `issue_valid` in 1: ID offers an instruction.
- `issue_rd` in 5, `issue_regwr` in 1: destination and write-enable of the offered instruction.
- `issue_md` in 1: offered instruction uses the mul/div unit.
- `issue_ready` out 1: instruction may leave ID this cycle.
- `wb0_valid` in 1, `wb0_rd` in 5: main-pipe retirement (writeback or squash) of an instruction that was counted.
- `wb1_valid` in 1, `wb1_rd` in 5: mul/div completion; also frees the unit.
- `pending_any` out 1: any counter nonzero or mul/div busy (drain condition for CSR/fence).
- `err` out 1: sticky protocol error.

## Operation
- State: `cnt[1..NREG-1]` (CNT_W bits each), `md_busy`, `err`.
- `fire = issue_valid & issue_ready`.
- `inc[r] = fire & issue_regwr & (issue_rd==r) & (r!=0)`.
- `dec[r] = (wb0_valid & wb0_rd==r) + (wb1_valid & wb1_rd==r)`, for r≠0 only; range 0..2.
- Next value: `cnt[r] + inc[r] - dec[r]`, computed at CNT_W+1 bits.
  - A negative result clamps to 0 and sets `err`.
- Source valid, for `rsN_valid`:
  - `rsN_addr==0` → 1.
  - `cnt==0` → 1.
  - `BYPASS & (cnt - dec)==0` → 1.
  - otherwise 0.
  - Independent of `rsN_used`.
- `issue_ready` is 0 if any of the following holds, else 1:
  - `rs1_used & ~rs1_valid`
  - `rs2_used & ~rs2_valid`
  - `issue_regwr & issue_rd!=0 & cnt[issue_rd]==MAX` (no credit for same-cycle retirement)
  - `issue_md & md_busy & ~wb1_valid`
- `issue_ready` is combinational and does not depend on `issue_valid`.
- `md_busy` next value:
  - set on `fire & issue_md`;
  - else cleared on `wb1_valid`;
  - same cycle: stays 1.
- `err` is also set by `wb1_valid & ~md_busy`.
- `err` clears only on `rst`.
- `pending_any = md_busy | OR(cnt != 0)`, registered state only.

## Timing
- Reset: all `cnt`=0, `md_busy`=0, `err`=0.
  - First cycle after reset: `rs*_valid`=1, `issue_ready`=1, `pending_any`=0.
- Issue at edge t → `cnt[rd]` updated at t+1; a dependent instruction in ID sees `rsN_valid=0` from t+1.
- Retirement at cycle t:
  - `BYPASS=1`: the dependent is valid in cycle t (same-cycle release).
  - `BYPASS=0`: the dependent is valid at t+1.
- Issue and retirement of the same reg in one cycle: net count unchanged.
- Issue and one retirement to a reg at MAX: the issue is still refused.
- Mul/div:
  - back-to-back MD issue is allowed in the cycle `wb1_valid` is asserted;
  - otherwise the second MD instruction stalls until that cycle.
- `rst` mid-operation:
  - all tracking is dropped next cycle;
  - later retirements of pre-reset instructions set `err` (the environment must not produce them).

## Test plan
- Reset, then `rs1_addr=5, rs1_used=1`, no issue → `rs1_valid=1`, `issue_ready=1`, `pending_any=0`, `err=0`.
- Issue `rd=5` at cycle 0; next instruction reads x5 → `rs1_valid=0`, `issue_ready=0` at cycle 1. `wb0_valid, wb0_rd=5` at cycle 3:
  - `BYPASS=1` → `issue_ready=1` in cycle 3;
  - `BYPASS=0` → `issue_ready=1` in cycle 4.
- Three issues to x7, then a fourth → the fourth stalls with `cnt=3`. Retire 2 at once via `wb0_rd=7` and `wb1_rd=7` (with `md_busy` set) → `cnt=1` next cycle, and the fourth issues.
- Issue MD (`issue_md=1, rd=9`), then an MD instruction in ID → `issue_ready=0` until the `wb1_valid, wb1_rd=9` cycle, where it is 1 and fires. `md_busy` stays 1; `pending_any` stays 1.
- `rd=0` issue with `issue_regwr=1` → no counter change; an x0 reader is always valid.
- Protocol errors:
  - `wb0_valid, wb0_rd=3` with `cnt[3]=0` → `err=1` next cycle, `cnt[3]=0`;
  - `wb1_valid` with `md_busy=0` → `err=1`;
  - `err` holds until `rst`.
